pipe_scheduler: RTL and testbench

//   Game sequencer for the scrolling column chain. Generates the one-cycle

---
 rtl/pipe_scheduler.sv | 150 +++++++++++++++
 tb/tb_pipe_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_scheduler.sv
// Game sequencer: scroll strobe, entry-column pipe pattern, score and run/pause/over FSM.
// Define PIPE_SPEEDUP_EN to shorten the tick period by TICK_STEP every 8 points, floored at TICK_MIN.
module pipe_scheduler #(
  parameter int         TICK_DIV     = 25000000,
  parameter int         PIPE_SPACING = 4,
  parameter int         BIRD_DIST    = 3,
  parameter int         GAP_H        = 3,
  parameter logic [7:0] SEED         = 8'hA5,
  parameter int         TICK_STEP    = 2500000,
  parameter int         TICK_MIN     = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       collide,
  output logic       enable2,
  output logic [7:0] pattern,
  output logic       col_clear,
  output logic       running,
  output logic       game_over,
  output logic [7:0] score
);

  localparam int DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (PIPE_SPACING > 2) ? $clog2(PIPE_SPACING) : 1;
  localparam logic [2:0]    MAXP     = 3'(8 - GAP_H);
  localparam logic [7:0]    GAP_MASK = 8'((1 << GAP_H) - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(PIPE_SPACING - 1);
  localparam logic [CW-1:0] COL_BIRD = CW'(BIRD_DIST);

  if (TICK_DIV < 2 || PIPE_SPACING <= BIRD_DIST || GAP_H < 2 || GAP_H > 4 ||
      SEED == 8'h00 || TICK_MIN < 1 || TICK_MIN > TICK_DIV || TICK_STEP < 0) begin : g_bad_params
    $error("pipe_scheduler: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, OVER} state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_last;
  logic [CW-1:0] col_cnt;
  logic [7:0]    lfsr;
  logic          pipe_seen;
  logic          lfsr_fb;
  logic [2:0]    gp;
  logic [7:0]    pipe_pat;

  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  // Fold out-of-range LFSR values back so the whole gap stays on screen.
  always_comb begin
    gp       = (lfsr[2:0] > MAXP) ? lfsr[2:0] - MAXP : lfsr[2:0];
    pipe_pat = ~(GAP_MASK << gp);
  end

`ifdef PIPE_SPEEDUP_EN
  localparam int SPAN = TICK_DIV - TICK_MIN;

  function automatic logic [DW-1:0] last_for(input logic [7:0] sc);
    logic [31:0] dec;
    dec = 32'(sc[7:3]) * 32'(TICK_STEP);
    if (dec >= 32'(SPAN)) return DW'(TICK_MIN - 1);
    return DW'(32'(TICK_DIV - 1) - dec);
  endfunction
`else
  assign div_last = DIV_LAST;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      enable2   <= 1'b0;
      pattern   <= 8'h00;
      col_clear <= 1'b0;
      running   <= 1'b0;
      game_over <= 1'b0;
      score     <= 8'h00;
      div_cnt   <= '0;
      col_cnt   <= '0;
      lfsr      <= SEED;
      pipe_seen <= 1'b0;
`ifdef PIPE_SPEEDUP_EN
      div_last  <= DIV_LAST;
`endif
    end else begin
      enable2   <= 1'b0;
      col_clear <= 1'b0;
      case (state)
        IDLE, OVER: begin
          if (start) begin
            state     <= RUN;
            running   <= 1'b1;
            game_over <= 1'b0;
            col_clear <= 1'b1;
            div_cnt   <= '0;
            col_cnt   <= '0;
            score     <= 8'h00;
            pipe_seen <= 1'b0;
            pattern   <= 8'h00;
`ifdef PIPE_SPEEDUP_EN
            div_last  <= DIV_LAST;
`endif
          end
        end
        RUN: begin
          if (collide) begin
            state     <= OVER;
            running   <= 1'b0;
            game_over <= 1'b1;
          end else begin
            if (pause) begin
              state   <= PAUSED;
              running <= 1'b0;
            end
            // A wrap that coincides with pause is held so the strobe never lands in PAUSED.
            if (div_cnt != div_last) begin
              div_cnt <= div_cnt + DW'(1);
            end else if (!pause) begin
              div_cnt <= '0;
              enable2 <= 1'b1;
              col_cnt <= (col_cnt == COL_LAST) ? '0 : col_cnt + CW'(1);
              if (col_cnt == '0) begin
                pattern   <= pipe_pat;
                lfsr      <= {lfsr[6:0], lfsr_fb};
                pipe_seen <= 1'b1;
              end else begin
                pattern <= 8'h00;
              end
              if (col_cnt == COL_BIRD && pipe_seen && score != 8'hFF)
                score <= score + 8'd1;
`ifdef PIPE_SPEEDUP_EN
              div_last <= last_for(score);
`endif
            end
          end
        end
        PAUSED: begin
          if (!pause) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_scheduler.sv
// Directed bench for pipe_scheduler with TICK_DIV=4, PIPE_SPACING=4, BIRD_DIST=3, GAP_H=3, SEED=A5.
module tb_pipe_scheduler;

  localparam int TICK_DIV     = 4;
  localparam int PIPE_SPACING = 4;
  localparam int BIRD_DIST    = 3;
  localparam int GAP_H        = 3;
  localparam int TICK_STEP    = 1;
  localparam int TICK_MIN     = 2;

  logic       clk = 1'b0;
  logic       reset, start, pause, collide;
  logic       enable2, col_clear, running, game_over;
  logic [7:0] pattern, score;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_scheduler #(
    .TICK_DIV(TICK_DIV), .PIPE_SPACING(PIPE_SPACING), .BIRD_DIST(BIRD_DIST),
    .GAP_H(GAP_H), .SEED(8'hA5), .TICK_STEP(TICK_STEP), .TICK_MIN(TICK_MIN)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .collide(collide),
    .enable2(enable2), .pattern(pattern), .col_clear(col_clear),
    .running(running), .game_over(game_over), .score(score)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Steps until the next strobe; run counts RUN cycles from the current one up to the strobe.
  task automatic wait_tick(output int cyc, output int run);
    cyc = 0;
    run = 0;
    do begin
      if (running) run++;
      step();
      cyc++;
    end while (!enable2 && cyc < 64);
    if (!enable2) chk("tick_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [7:0] m_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic [7:0] m_pipe(input logic [7:0] s);
    int r, g;
    logic [7:0] m;
    r = int'(s[2:0]);
    g = (r > 8 - GAP_H) ? r - (8 - GAP_H) : r;
    m = 8'((1 << GAP_H) - 1) << g;
    return ~m;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc, run, c2, r2, hits, runs, clr, ovr;
    int col_m, score_m, min_gap, max_gap;
    logic [7:0] lfsr_m;
    logic [7:0] exp_pat [5];
    exp_pat = '{8'hE3, 8'h00, 8'h00, 8'h00, 8'h1F};

    reset = 1'b1; start = 1'b0; pause = 1'b0; collide = 1'b0;
    repeat (3) step();
    chk("rst_enable2",   32'(enable2),   32'd0);
    chk("rst_pattern",   32'(pattern),   32'd0);
    chk("rst_col_clear", 32'(col_clear), 32'd0);
    chk("rst_running",   32'(running),   32'd0);
    chk("rst_game_over", 32'(game_over), 32'd0);
    chk("rst_score",     32'(score),     32'd0);

    reset = 1'b0;
    hits = 0; runs = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      hits += int'(enable2);
      runs += int'(running);
    end
    chk("idle_enable2", hits, 0);
    chk("idle_running", runs, 0);
    chk("idle_pattern", 32'(pattern), 32'd0);

    // Game 1
    start = 1'b1; step(); start = 1'b0;
    chk("start_col_clear", 32'(col_clear), 32'd1);
    chk("start_running",   32'(running),   32'd1);
    step();
    chk("col_clear_width", 32'(col_clear), 32'd0);
    wait_tick(cyc, run);
    chk("tick1_delay",   cyc + 1, 4);
    chk("tick1_pattern", 32'(pattern), 32'h1F);
    chk("tick1_score",   32'(score), 32'd0);
    step();
    chk("enable2_width", 32'(enable2), 32'd0);
    chk("pattern_hold",  32'(pattern), 32'h1F);
    wait_tick(cyc, run);
    chk("tick2_gap",     cyc + 1, 4);
    chk("tick2_pattern", 32'(pattern), 32'd0);

    // Pause mid-interval; start and collide must be ignored while paused.
    run = 1;
    step();
    run += int'(running);
    pause = 1'b1;
    hits = 0; runs = 0; clr = 0; ovr = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      hits += int'(enable2);
      runs += int'(running);
      clr  += int'(col_clear);
      ovr  += int'(game_over);
      start   = (i == 2);
      collide = (i >= 4 && i <= 6);
    end
    pause = 1'b0;
    chk("pause_enable2",         hits, 0);
    chk("pause_running",         runs, 0);
    chk("pause_start_ignored",   clr,  0);
    chk("pause_collide_ignored", ovr,  0);
    wait_tick(c2, r2);
    chk("tick3_run_cycles", run + r2, 4);
    chk("tick3_pattern",    32'(pattern), 32'd0);
    chk("tick3_score",      32'(score), 32'd0);
    wait_tick(cyc, run);
    chk("tick4_gap",     cyc, 4);
    chk("tick4_pattern", 32'(pattern), 32'd0);
    chk("tick4_score",   32'(score), 32'd1);

    start = 1'b1; step(); start = 1'b0;
    chk("run_start_ignored", 32'(col_clear), 32'd0);
    chk("run_start_running", 32'(running),   32'd1);
    wait_tick(cyc, run);
    chk("tick5_gap",     cyc + 1, 4);
    chk("tick5_pattern", 32'(pattern), 32'hE3);
    for (int k = 1; k < 5; k++) begin
      wait_tick(cyc, run);
      chk("tick6to9_gap",     cyc, 4);
      chk("tick6to9_pattern", 32'(pattern), 32'(exp_pat[k]));
    end
    chk("tick9_score", 32'(score), 32'd2);

    // Collide wins over pause.
    step();
    collide = 1'b1; pause = 1'b1;
    step();
    chk("collide_game_over", 32'(game_over), 32'd1);
    chk("collide_running",   32'(running),   32'd0);
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      hits += int'(enable2);
    end
    chk("over_enable2", hits, 0);
    chk("over_score",   32'(score),   32'd2);
    chk("over_pattern", 32'(pattern), 32'h1F);

    // Game 2: LFSR continues from 8'h2A, so the first pipe differs from the SEED one.
    collide = 1'b0; pause = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    chk("restart_col_clear", 32'(col_clear), 32'd1);
    chk("restart_running",   32'(running),   32'd1);
    chk("restart_game_over", 32'(game_over), 32'd0);
    chk("restart_score",     32'(score),     32'd0);
    chk("restart_pattern",   32'(pattern),   32'd0);
    wait_tick(cyc, run);
    chk("restart_pipe", 32'(pattern), 32'hE3);

    lfsr_m = m_next(8'h2A);
    col_m = 1; score_m = 0; min_gap = 1000; max_gap = 0;
    for (int t = 0; t < 1199; t++) begin
      wait_tick(cyc, run);
      if (cyc < min_gap) min_gap = cyc;
      if (cyc > max_gap) max_gap = cyc;
      if (col_m == 0) begin
        chk("run_pipe", 32'(pattern), 32'(m_pipe(lfsr_m)));
        lfsr_m = m_next(lfsr_m);
      end else begin
        chk("run_empty", 32'(pattern), 32'd0);
      end
      if (col_m == BIRD_DIST) begin
        if (score_m < 255) score_m++;
        chk("run_score", 32'(score), score_m);
      end
      col_m = (col_m == PIPE_SPACING - 1) ? 0 : col_m + 1;
    end
    chk("score_saturated", 32'(score), 32'hFF);
`ifdef PIPE_SPEEDUP_EN
    chk("min_gap", min_gap, TICK_MIN);
`else
    chk("min_gap", min_gap, TICK_DIV);
`endif
    chk("max_gap", max_gap, TICK_DIV);

    // Reset mid-game.
    reset = 1'b1; step();
    chk("midrst_running", 32'(running), 32'd0);
    chk("midrst_score",   32'(score),   32'd0);
    chk("midrst_pattern", 32'(pattern), 32'd0);
    reset = 1'b0;
    hits = 0; runs = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      hits += int'(enable2);
      runs += int'(running);
    end
    chk("midrst_idle_enable2", hits, 0);
    chk("midrst_idle_running", runs, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
